// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = a - b, LSB first, one bit per clock.
// Shares FSM, start/done handshake and output shift style with the serial adder
// so both can sit behind the same serial-arithmetic controller.
module sub_serial #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2,
    BAD  = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    count;
  logic             borrow_r;
  logic             diff_bit;
  logic             borrow_nxt;

  // Difference bit of a one-bit full subtractor.
  function automatic logic diff_of(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  // Borrow-out of a one-bit full subtractor (x - y - bi).
  function automatic logic borrow_of(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  assign diff_bit   = diff_of(a_reg[0], b_reg[0], borrow_r);
  assign borrow_nxt = borrow_of(a_reg[0], b_reg[0], borrow_r);

  // Status is decoded from the registered state only, so no input reaches these.
  assign busy = (state == SUB);
  assign done = (state == DONE);

  // FSM plus operand/result shift registers; one result bit per SUB cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      out      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      count    <= '0;
      borrow_r <= 1'b0;
      borrow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            a_reg    <= a;
            b_reg    <= b;
            out      <= '0;
            count    <= '0;
            borrow_r <= 1'b0;
            borrow   <= 1'b0;
            state    <= SUB;
          end
        end
        SUB: begin
          // Result enters at the MSB and walks right, so after WIDTH shifts
          // the first (LSB) difference bit lands in out[0].
          out      <= {diff_bit, out[WIDTH-1:1]};
          borrow_r <= borrow_nxt;
          a_reg    <= a_reg >> 1;
          b_reg    <= b_reg >> 1;
          count    <= count + CW'(1);
          if (count == LAST) begin
            borrow <= borrow_nxt;
            state  <= DONE;
          end
        end
        DONE: begin
          // Start requests are deliberately ignored here; the next one is
          // taken from IDLE, giving the WIDTH+2 start-to-start spacing.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Testbench for sub_serial: WIDTH=8 and WIDTH=4 instances against an
// arithmetic reference model (modular difference, unsigned compare).
module tb_sub_serial;

  logic       clk;
  logic       rst;
  logic       en8, en4;
  logic [7:0] a8, b8, out8;
  logic [3:0] a4, b4, out4;
  logic       borrow8, busy8, done8;
  logic       borrow4, busy4, done4;

  int checks = 0;
  int errors = 0;

  logic       sel4;
  logic [7:0] obs_out;
  logic       obs_borrow, obs_busy, obs_done;

  assign obs_out    = sel4 ? {4'h0, out4} : out8;
  assign obs_borrow = sel4 ? borrow4 : borrow8;
  assign obs_busy   = sel4 ? busy4 : busy8;
  assign obs_done   = sel4 ? done4 : done8;

  sub_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8),
    .out(out8), .borrow(borrow8), .busy(busy8), .done(done8)
  );

  sub_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .a(a4), .b(b4),
    .out(out4), .borrow(borrow4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_diff(input int w, input logic [7:0] x, input logic [7:0] y);
    int unsigned m;
    m = (1 << w);
    return 8'((int'(x) - int'(y) + int'(m)) % int'(m));
  endfunction

  function automatic logic model_borrow(input logic [7:0] x, input logic [7:0] y);
    return (x < y);
  endfunction

  task automatic test_reset();
    rst = 1'b0; en8 = 0; en4 = 0; a8 = 0; b8 = 0; a4 = 0; b4 = 0; sel4 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out8, borrow8, busy8, done8} !== 11'd0) begin
      errors++; $display("FAIL reset8 got out=%h b=%b busy=%b done=%b want all 0", out8, borrow8, busy8, done8);
    end
    checks++;
    if ({out4, borrow4, busy4, done4} !== 7'd0) begin
      errors++; $display("FAIL reset4 got out=%h b=%b busy=%b done=%b want all 0", out4, borrow4, busy4, done4);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy8, done8);
    end
  endtask

  // One operation with a single-cycle en pulse; checks timing, result and hold.
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv, input string nm);
    logic [7:0] mask, am, bm, exp_o;
    logic       exp_b;
    int         busy_cnt, lat;
    bit         seen;
    mask  = (w == 8) ? 8'hFF : 8'h0F;
    am    = av & mask;
    bm    = bv & mask;
    exp_o = model_diff(w, am, bm);
    exp_b = model_borrow(am, bm);
    sel4  = (w != 8);
    @(negedge clk);
    if (w == 8) begin en8 = 1; a8 = am; b8 = bm; end
    else begin en4 = 1; a4 = am[3:0]; b4 = bm[3:0]; end
    busy_cnt = 0; lat = 0; seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin en8 = 0; en4 = 0; end
      if (obs_busy) busy_cnt++;
      if (obs_done) begin seen = 1; lat = k; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s_timeout got no done want done after %0d cycles", nm, w + 1);
      return;
    end
    checks++;
    if (lat != w + 1 || busy_cnt != w) begin
      errors++; $display("FAIL %s_timing got done@%0d busy=%0d want done@%0d busy=%0d", nm, lat, busy_cnt, w + 1, w);
    end
    checks++;
    if (obs_out !== exp_o || obs_borrow !== exp_b) begin
      errors++; $display("FAIL %s_result a=%h b=%h got out=%h borrow=%b want out=%h borrow=%b", nm, am, bm, obs_out, obs_borrow, exp_o, exp_b);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (obs_done !== 1'b0 || obs_busy !== 1'b0 || obs_out !== exp_o || obs_borrow !== exp_b) begin
      errors++; $display("FAIL %s_hold got done=%b busy=%b out=%h borrow=%b want 0 0 %h %b", nm, obs_done, obs_busy, obs_out, obs_borrow, exp_o, exp_b);
    end
  endtask

  task automatic test_directed();
    run_op(8, 8'h05, 8'h03, "d_05_03");
    run_op(8, 8'h03, 8'h05, "d_03_05");
    run_op(8, 8'h00, 8'h01, "d_00_01");
    run_op(8, 8'hFF, 8'hFF, "d_FF_FF");
    run_op(4, 8'h02, 8'h07, "w4_2_7");
  endtask

  task automatic test_random();
    logic [7:0] x, y;
    for (int i = 0; i < 12; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      run_op(8, x, y, "rand8");
    end
    for (int i = 0; i < 6; i++) begin
      x = 8'($urandom_range(0, 15)); y = 8'($urandom_range(0, 15));
      run_op(4, x, y, "rand4");
    end
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    logic [7:0] res[$];
    logic       brw[$];
    sel4 = 0;
    @(negedge clk);
    en8 = 1; a8 = 8'h10; b8 = 8'h01;
    for (int k = 1; k <= 40 && done_at.size() < 2; k++) begin
      @(negedge clk);
      if (k == 1) begin a8 = 8'h80; b8 = 8'h7F; end
      if (done8) begin done_at.push_back(k); res.push_back(out8); brw.push_back(borrow8); end
      if (done_at.size() == 2) en8 = 0;
    end
    en8 = 0;
    checks++;
    if (done_at.size() != 2) begin
      errors++; $display("FAIL b2b_count got %0d done pulses want 2", done_at.size());
      return;
    end
    checks++;
    if (done_at[1] - done_at[0] != 10) begin
      errors++; $display("FAIL b2b_spacing got %0d want 10", done_at[1] - done_at[0]);
    end
    checks++;
    if (res[0] !== 8'h0F || brw[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_first got %h/%b want 0f/0", res[0], brw[0]);
    end
    checks++;
    if (res[1] !== 8'h01 || brw[1] !== 1'b0) begin
      errors++; $display("FAIL b2b_second got %h/%b want 01/0", res[1], brw[1]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ignore_inputs();
    int  n_done;
    bit  seen;
    sel4 = 0;
    @(negedge clk);
    en8 = 1; a8 = 8'h05; b8 = 8'h03;
    n_done = 0; seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      en8 = (k >= 3);
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (done8) begin seen = 1; n_done++; end
    end
    en8 = 0;
    checks++;
    if (!seen || out8 !== 8'h02 || borrow8 !== 1'b0) begin
      errors++; $display("FAIL ignore_result got seen=%0b out=%h borrow=%b want 1 02 0", seen, out8, borrow8);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) n_done++;
    end
    checks++;
    if (n_done != 1 || out8 !== 8'h02) begin
      errors++; $display("FAIL ignore_extra got pulses=%0d out=%h want 1 02", n_done, out8);
    end
  endtask

  task automatic test_reset_mid_sub();
    int bad;
    sel4 = 0;
    @(negedge clk);
    en8 = 1; a8 = 8'h05; b8 = 8'h03;
    @(negedge clk);
    en8 = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy8 !== 1'b1) begin
      errors++; $display("FAIL midsub_busy got busy=%b want 1", busy8);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out8 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++; $display("FAIL async_reset got out=%h busy=%b done=%b want 00 0 0", out8, busy8, done8);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy8 || done8 || out8 != 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_stays_idle got %0d bad cycles want 0", bad);
    end
    run_op(8, 8'h20, 8'h01, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_inputs();
    test_reset_mid_sub();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
Bit-serial subtractor, the inverse operation of the team's bit-serial adder. It computes out = a - b, LSB first, one bit per clock, and reports a final borrow. Its FSM, start/done handshake and output-register shift style match the adder, so both can sit behind the same serial-arithmetic controller. Operands are captured on start; the result stays held until the next start.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)
CW, $clog2(WIDTH), bit-counter width (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (0 = reset)
en  input  1  start request, sampled only in IDLE
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
out  output  WIDTH  difference register, filled MSB-side by right shift
borrow  output  1  final borrow (1 = a < b unsigned), valid with done/after
busy  output  1  high in SUB state
done  output  1  one-cycle pulse in DONE state

Behaviour:
- Reset (rst=0, async, takes effect immediately): state=IDLE; out, a_reg, b_reg, count, borrow, internal borrow_r all 0; busy=0; done=0.
- States, 2-bit encoding: IDLE=0, SUB=1, DONE=2. Encoding 3 is unreachable; if reached it returns to IDLE on the next edge with no register updates.
- IDLE:
  - en=1 at an edge: a_reg<=a, b_reg<=b, out<=0, count<=0, borrow_r<=0, borrow<=0, state<=SUB.
  - en=0: hold all registers; out and borrow keep the previous result.
- SUB, each edge:
  - d = a_reg[0]^b_reg[0]^borrow_r
  - out <= {d, out[WIDTH-1:1]}
  - borrow_r <= (~a_reg[0]&b_reg[0]) | (~(a_reg[0]^b_reg[0])&borrow_r)
  - a_reg, b_reg shift right by 1 (zero fill)
  - count <= count+1
  - When count==WIDTH-1: state<=DONE and borrow <= the borrow_r next value computed this cycle. Otherwise stay in SUB.
- DONE: done=1 for exactly one cycle; state<=IDLE unconditionally. An en in DONE is ignored; no start is accepted here.
- Outputs busy and done are decoded from the state (registered state, no comb path from inputs).
- Latency: start accepted at edge E0. SUB occupies edges E1..E_WIDTH. done is high in the cycle after E_WIDTH. out and borrow are final from that cycle and held until the next accepted start. Start to done = WIDTH+1 cycles.
- Minimum start-to-start spacing is WIDTH+2 edges: E0, WIDTH SUB edges, DONE edge, then the IDLE edge that accepts the next start. en held high continuously gives back-to-back operations at that spacing.
- en, a and b changes during SUB/DONE have no effect.
- Arithmetic is modulo 2^WIDTH, unsigned. borrow equals the carry-out complement of a + ~b + 1.
- Reset asserted mid-SUB aborts the operation. After release the block is in IDLE with out=0 and requires a new en.

Test Plan:
- a=8'h05, b=8'h03, en pulse 1 cycle -> busy high 8 cycles; done pulse 9 cycles after start; out=8'h02, borrow=0.
- a=8'h03, b=8'h05 -> out=8'hFE, borrow=1. a=8'h00, b=8'h01 -> out=8'hFF, borrow=1. a=8'hFF, b=8'hFF -> out=8'h00, borrow=0.
- en held high, operands 8'h10-8'h01 then 8'h80-8'h7F -> two done pulses 10 cycles apart; results 8'h0F then 8'h01, both borrow=0.
- Start a=8'h05, b=8'h03; change a/b and pulse en during SUB and during DONE -> result still 8'h02; no extra done pulse.
- Start, then drive rst=0 at cycle 4 of SUB -> immediate out=0, busy=0, done=0. After release with no en, stays IDLE. A new start with 8'h20-8'h01 gives 8'h1F.
- WIDTH=4 instance, a=4'h2, b=4'h7 -> out=4'hB, borrow=1, done 5 cycles after start.
